// File: rtl/seq_pattern_pkg.sv
// ---------------------------------------------------------------------------
// seq_pattern_pkg
// Shared definitions for the serial bit-pattern transmitter slice.
//   state_t : transmitter FSM states (IDLE, SEND, GAP, DONE)
//   PAT_W   : default maximum pattern length in bits
//   LEN_W   : default width of the length field (must be able to hold PAT_W)
//   REP_W   : default width of the repetition count field
//   GAP_W   : default width of the inter-repeat gap field
// ---------------------------------------------------------------------------
package seq_pattern_pkg;

   localparam int PAT_W = 8;
   localparam int LEN_W = 4;
   localparam int REP_W = 4;
   localparam int GAP_W = 4;

   // Transmitter states: waiting for a request, shifting pattern bits,
   // idling between repetitions, and the one-cycle completion state.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx_if
// Request/response and serial-stream bundle of the pattern transmitter.
//   start     : request strobe (master -> slave)
//   pat       : pattern, bits [len-1:0] are sent MSB-first (master -> slave)
//   len       : bits per repetition (master -> slave)
//   reps      : number of repetitions (master -> slave)
//   gap       : idle cycles between repetitions (master -> slave)
//   ready     : transmitter idle and able to accept start (slave -> master)
//   busy      : request in progress, through the done cycle (slave -> master)
//   done      : one-cycle completion pulse (slave -> master)
//   ser_out   : serial data bit (slave -> master)
//   ser_valid : ser_out carries a pattern bit (slave -> master)
// The master modport is the requester / stream consumer; the slave modport
// is the transmitter itself.
// ---------------------------------------------------------------------------
interface seq_pattern_tx_if #(
   parameter int PAT_W = seq_pattern_pkg::PAT_W,
   parameter int LEN_W = seq_pattern_pkg::LEN_W,
   parameter int REP_W = seq_pattern_pkg::REP_W,
   parameter int GAP_W = seq_pattern_pkg::GAP_W
) ();
   import seq_pattern_pkg::*;

   logic             start;
   logic [PAT_W-1:0] pat;
   logic [LEN_W-1:0] len;
   logic [REP_W-1:0] reps;
   logic [GAP_W-1:0] gap;
   logic             ready;
   logic             busy;
   logic             done;
   logic             ser_out;
   logic             ser_valid;

   modport master (
      output start, pat, len, reps, gap,
      input  ready, busy, done, ser_out, ser_valid
   );

   modport slave (
      input  start, pat, len, reps, gap,
      output ready, busy, done, ser_out, ser_valid
   );

endinterface

// File: rtl/seq_pattern_piso.sv
// ---------------------------------------------------------------------------
// seq_pattern_piso
// Parallel-in, serial-out shift register, MSB first.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, clears the register
//   load      : load load_data (takes priority over shift)
//   shift     : shift left by one, filling with zero
//   load_data : pattern already aligned so its first bit sits in the MSB
//   ser_bit   : current bit (register MSB)
// Because zeros are shifted in and the loaded pattern has zeros below its
// valid bits, the register drains to all-zero after the last valid bit.
// The transmitter relies on that so the serial line idles low for free.
// ---------------------------------------------------------------------------
module seq_pattern_piso #(
   parameter int PAT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [PAT_W-1:0] load_data,
   output logic             ser_bit
);

   logic [PAT_W-1:0] shift_reg;

   // Shift register: reset clears, load replaces the contents, shift moves
   // the next bit into the MSB position.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
      end else if (load) begin
         shift_reg <= load_data;
      end else if (shift) begin
         shift_reg <= shift_reg << 1;
      end
   end

   assign ser_bit = shift_reg[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
// Serial bit-pattern transmitter. Accepts a pattern, length, repetition count
// and gap, then sends bits [len-1:0] MSB-first, one per clock, repeating the
// pattern reps times with gap idle cycles between repetitions.
//   clk : clock, rising edge
//   rst : synchronous active-high reset; aborts any transfer without done
//   bus : seq_pattern_tx_if slave modport
//         (start/pat/len/reps/gap in, ready/busy/done/ser_out/ser_valid out)
// All outputs come straight from flops. Zero length or zero repetitions
// complete immediately; lengths above PAT_W are clamped to PAT_W.
// ---------------------------------------------------------------------------
module seq_pattern_tx #(
   parameter int PAT_W = seq_pattern_pkg::PAT_W,
   parameter int LEN_W = seq_pattern_pkg::LEN_W,
   parameter int REP_W = seq_pattern_pkg::REP_W,
   parameter int GAP_W = seq_pattern_pkg::GAP_W
) (
   input  logic          clk,
   input  logic          rst,
   seq_pattern_tx_if.slave bus
);
   import seq_pattern_pkg::*;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             valid_q, valid_d;
   logic [LEN_W-1:0] len_clamped;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic             piso_load;
   logic             piso_shift;
   logic [PAT_W-1:0] piso_data;
   logic             piso_bit;

   // Keep only bits [n-1:0] of the pattern and move them to the top of the
   // word, so that bit n-1 is the first one out of the shift register and
   // everything below the pattern is zero.
   function automatic logic [PAT_W-1:0] align_pattern(
      input logic [PAT_W-1:0] p,
      input logic [LEN_W-1:0] n
   );
      logic [PAT_W-1:0] mask;
      mask = ~({PAT_W{1'b1}} << n);
      return (p & mask) << (LEN_W'(PAT_W) - n);
   endfunction

   // Next-state and next-output logic. Outputs are computed for the state we
   // are about to enter, so that once registered they line up with it: the
   // first bit appears the cycle after start is accepted, and done appears
   // the cycle after the last bit. The bit counter holds the number of bits
   // still to send after the current one, the repetition counter the number
   // of repetitions still to start, and the gap counter the idle cycles left
   // after the current one; reaching zero is what triggers each transition.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      len_d       = len_q;
      rep_cnt_d   = rep_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      gap_d       = gap_q;
      pat_d       = pat_q;
      ready_d     = 1'b0;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      valid_d     = 1'b0;
      piso_load   = 1'b0;
      piso_shift  = 1'b0;
      piso_data   = pat_q;
      len_clamped = (bus.len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.len;

      unique case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (bus.start) begin
               ready_d = 1'b0;
               busy_d  = 1'b1;
               if (len_clamped == '0 || bus.reps == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = SEND;
                  valid_d   = 1'b1;
                  len_d     = len_clamped;
                  bit_cnt_d = len_clamped - LEN_W'(1);
                  rep_cnt_d = bus.reps - REP_W'(1);
                  gap_d     = bus.gap;
                  pat_d     = align_pattern(bus.pat, len_clamped);
                  piso_data = align_pattern(bus.pat, len_clamped);
                  piso_load = 1'b1;
               end
            end
         end

         SEND: begin
            if (bit_cnt_q != '0) begin
               bit_cnt_d  = bit_cnt_q - LEN_W'(1);
               piso_shift = 1'b1;
               valid_d    = 1'b1;
            end else if (rep_cnt_q == '0) begin
               state_d    = DONE;
               done_d     = 1'b1;
               piso_shift = 1'b1;
            end else begin
               rep_cnt_d = rep_cnt_q - REP_W'(1);
               if (gap_q == '0) begin
                  bit_cnt_d = len_q - LEN_W'(1);
                  piso_load = 1'b1;
                  valid_d   = 1'b1;
               end else begin
                  state_d    = GAP;
                  gap_cnt_d  = gap_q - GAP_W'(1);
                  piso_shift = 1'b1;
               end
            end
         end

         GAP: begin
            if (gap_cnt_q == '0) begin
               state_d   = SEND;
               bit_cnt_d = len_q - LEN_W'(1);
               piso_load = 1'b1;
               valid_d   = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, counter, captured-request and output registers. Reset wins over
   // everything else, so a reset during a transfer drops straight back to
   // IDLE with no done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         len_q     <= '0;
         rep_cnt_q <= '0;
         gap_cnt_q <= '0;
         gap_q     <= '0;
         pat_q     <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         len_q     <= len_d;
         rep_cnt_q <= rep_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         gap_q     <= gap_d;
         pat_q     <= pat_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
      end
   end

   // The shift register drains to zero after every repetition and is
   // cleared by reset, so its MSB can drive the serial line directly and is
   // low whenever ser_valid is low.
   seq_pattern_piso #(
      .PAT_W (PAT_W)
   ) u_piso (
      .clk       (clk),
      .rst       (rst),
      .load      (piso_load),
      .shift     (piso_shift),
      .load_data (piso_data),
      .ser_bit   (piso_bit)
   );

   assign bus.ready     = ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.ser_valid = valid_q;
   assign bus.ser_out   = piso_bit;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_tx
// Self-checking bench for seq_pattern_tx. Expected serial streams come from
// a reference model that simply lists, cycle by cycle, the bits the
// transmitter should send for a request.
// ---------------------------------------------------------------------------
module tb_seq_pattern_tx;
   import seq_pattern_pkg::*;

   localparam int MAX_CYC = 600;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seq_pattern_tx_if bus ();

   seq_pattern_tx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_compared = 0;
   int   n_failed   = 0;
   logic exp_v[$];
   logic exp_b[$];
   logic obs_v[$];
   logic obs_b[$];
   int   obs_done_at;
   int   obs_hs_err;
   logic obs_done_valid;
   logic obs_ready_after;
   logic obs_busy_after;
   logic obs_done_after;
   int   inject_at = 0;
   logic [7:0] inject_pat = 8'h00;

   // Reference model: the stream is reps copies of pat[n-1..0] with gap
   // idle cycles between copies, n being len clamped to PAT_W.
   task automatic build_model(input logic [7:0] p, input int l, input int r, input int g);
      int n;
      exp_v.delete();
      exp_b.delete();
      n = (l > PAT_W) ? PAT_W : l;
      if (n == 0 || r == 0) return;
      for (int k = 0; k < r; k++) begin
         for (int i = n - 1; i >= 0; i--) begin
            exp_v.push_back(1'b1);
            exp_b.push_back(p[i]);
         end
         if (k != r - 1) begin
            for (int j = 0; j < g; j++) begin
               exp_v.push_back(1'b0);
               exp_b.push_back(1'b0);
            end
         end
      end
   endtask

   // Drive one request (called just after a falling edge) and record the
   // stream up to the done pulse, plus the handshake one cycle later.
   // Optionally pulses start with another pattern in the middle.
   task automatic applyStimulus(input logic [7:0] p, input int l, input int r, input int g);
      bit fin;
      obs_v.delete();
      obs_b.delete();
      obs_done_at    = -1;
      obs_hs_err     = 0;
      obs_done_valid = 1'b0;
      bus.pat   = p;
      bus.len   = 4'(l);
      bus.reps  = 4'(r);
      bus.gap   = 4'(g);
      bus.start = 1'b1;
      fin = 1'b0;
      for (int k = 1; k <= MAX_CYC && !fin; k++) begin
         @(negedge clk);
         if (k == inject_at) begin
            bus.start = 1'b1;
            bus.pat   = inject_pat;
            bus.len   = 4'd8;
            bus.reps  = 4'd1;
            bus.gap   = 4'd0;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done === 1'b1) begin
            obs_done_at    = k;
            obs_done_valid = bus.ser_valid;
            if (bus.busy !== 1'b1 || bus.ready !== 1'b0) obs_hs_err++;
            fin = 1'b1;
         end else begin
            obs_v.push_back(bus.ser_valid);
            obs_b.push_back(bus.ser_out);
            if (bus.busy !== 1'b1 || bus.ready !== 1'b0) obs_hs_err++;
         end
      end
      @(negedge clk);
      bus.start       = 1'b0;
      obs_ready_after = bus.ready;
      obs_busy_after  = bus.busy;
      obs_done_after  = bus.done;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.pat   = 8'hFF;
      bus.len   = 4'd8;
      bus.reps  = 4'd2;
      bus.gap   = 4'd0;
      repeat (3) @(negedge clk);
      n_compared++;
      if (bus.ready !== 1'b1) begin n_failed++; $display("[TB] FAIL reset_ready: got %b want 1", bus.ready); end
      n_compared++;
      if (bus.busy !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
      n_compared++;
      if (bus.done !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
      n_compared++;
      if (bus.ser_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_valid: got %b want 0", bus.ser_valid); end
      n_compared++;
      if (bus.ser_out !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_ser_out: got %b want 0", bus.ser_out); end
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      n_compared++;
      if (bus.ready !== 1'b1 || bus.ser_valid !== 1'b0) begin
         n_failed++;
         $display("[TB] FAIL reset_idle: got ready=%b valid=%b want ready=1 valid=0", bus.ready, bus.ser_valid);
      end
   endtask

   task automatic test_directed();
      logic [7:0] tp[5] = '{8'h05, 8'h05, 8'h02, 8'hA5, 8'h01};
      int tl[5] = '{3, 3, 2, 8, 1};
      int tr[5] = '{1, 2, 3, 2, 4};
      int tg[5] = '{0, 0, 2, 1, 3};
      for (int t = 0; t < 5; t++) begin
         build_model(tp[t], tl[t], tr[t], tg[t]);
         applyStimulus(tp[t], tl[t], tr[t], tg[t]);
         n_compared++;
         if (obs_done_at !== exp_v.size() + 1) begin
            n_failed++;
            $display("[TB] FAIL directed%0d done_cycle: got %0d want %0d", t, obs_done_at, exp_v.size() + 1);
         end
         for (int i = 0; i < exp_v.size(); i++) begin
            n_compared++;
            if (i >= obs_v.size() || obs_v[i] !== exp_v[i] || obs_b[i] !== exp_b[i]) begin
               n_failed++;
               $display("[TB] FAIL directed%0d bit%0d: got v=%b d=%b want v=%b d=%b", t, i,
                        (i < obs_v.size()) ? obs_v[i] : 1'bx, (i < obs_b.size()) ? obs_b[i] : 1'bx, exp_v[i], exp_b[i]);
            end
         end
         n_compared++;
         if (obs_hs_err !== 0 || obs_done_valid !== 1'b0 || obs_ready_after !== 1'b1 || obs_busy_after !== 1'b0 || obs_done_after !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL directed%0d handshake: got errs=%0d dvalid=%b ready=%b busy=%b done=%b want 0 0 1 0 0",
                     t, obs_hs_err, obs_done_valid, obs_ready_after, obs_busy_after, obs_done_after);
         end
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_degenerate();
      logic [7:0] tp[4] = '{8'hC3, 8'h3C, 8'h96, 8'h5A};
      int tl[4] = '{0, 5, 12, 15};
      int tr[4] = '{5, 0, 1, 2};
      int tg[4] = '{3, 3, 0, 2};
      for (int t = 0; t < 4; t++) begin
         build_model(tp[t], tl[t], tr[t], tg[t]);
         applyStimulus(tp[t], tl[t], tr[t], tg[t]);
         n_compared++;
         if (obs_done_at !== exp_v.size() + 1) begin
            n_failed++;
            $display("[TB] FAIL degenerate%0d done_cycle: got %0d want %0d", t, obs_done_at, exp_v.size() + 1);
         end
         for (int i = 0; i < exp_v.size(); i++) begin
            n_compared++;
            if (i >= obs_v.size() || obs_v[i] !== exp_v[i] || obs_b[i] !== exp_b[i]) begin
               n_failed++;
               $display("[TB] FAIL degenerate%0d bit%0d: got v=%b d=%b want v=%b d=%b", t, i,
                        (i < obs_v.size()) ? obs_v[i] : 1'bx, (i < obs_b.size()) ? obs_b[i] : 1'bx, exp_v[i], exp_b[i]);
            end
         end
         n_compared++;
         if (obs_hs_err !== 0 || obs_done_valid !== 1'b0 || obs_ready_after !== 1'b1 || obs_busy_after !== 1'b0 || obs_done_after !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL degenerate%0d handshake: got errs=%0d dvalid=%b ready=%b busy=%b done=%b want 0 0 1 0 0",
                     t, obs_hs_err, obs_done_valid, obs_ready_after, obs_busy_after, obs_done_after);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_start();
      logic [7:0] p;
      p          = 8'hB4;
      inject_at  = 3;
      inject_pat = ~p;
      build_model(p, 8, 2, 2);
      applyStimulus(p, 8, 2, 2);
      inject_at = 0;
      n_compared++;
      if (obs_done_at !== exp_v.size() + 1) begin
         n_failed++;
         $display("[TB] FAIL ignore_start done_cycle: got %0d want %0d", obs_done_at, exp_v.size() + 1);
      end
      for (int i = 0; i < exp_v.size(); i++) begin
         n_compared++;
         if (i >= obs_v.size() || obs_v[i] !== exp_v[i] || obs_b[i] !== exp_b[i]) begin
            n_failed++;
            $display("[TB] FAIL ignore_start bit%0d: got v=%b d=%b want v=%b d=%b", i,
                     (i < obs_v.size()) ? obs_v[i] : 1'bx, (i < obs_b.size()) ? obs_b[i] : 1'bx, exp_v[i], exp_b[i]);
         end
      end
      n_compared++;
      if (obs_hs_err !== 0 || obs_ready_after !== 1'b1 || obs_done_after !== 1'b0) begin
         n_failed++;
         $display("[TB] FAIL ignore_start handshake: got errs=%0d ready=%b done=%b want 0 1 0",
                  obs_hs_err, obs_ready_after, obs_done_after);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] p;
      int l, r, g;
      for (int t = 0; t < 4; t++) begin
         p = 8'($urandom);
         l = $urandom_range(1, 8);
         r = $urandom_range(1, 3);
         g = $urandom_range(0, 2);
         build_model(p, l, r, g);
         applyStimulus(p, l, r, g);
         n_compared++;
         if (obs_done_at !== exp_v.size() + 1) begin
            n_failed++;
            $display("[TB] FAIL b2b%0d done_cycle: got %0d want %0d", t, obs_done_at, exp_v.size() + 1);
         end
         for (int i = 0; i < exp_v.size(); i++) begin
            n_compared++;
            if (i >= obs_v.size() || obs_v[i] !== exp_v[i] || obs_b[i] !== exp_b[i]) begin
               n_failed++;
               $display("[TB] FAIL b2b%0d bit%0d: got v=%b d=%b want v=%b d=%b", t, i,
                        (i < obs_v.size()) ? obs_v[i] : 1'bx, (i < obs_b.size()) ? obs_b[i] : 1'bx, exp_v[i], exp_b[i]);
            end
         end
         n_compared++;
         if (obs_hs_err !== 0 || obs_ready_after !== 1'b1 || obs_busy_after !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL b2b%0d handshake: got errs=%0d ready=%b busy=%b want 0 1 0",
                     t, obs_hs_err, obs_ready_after, obs_busy_after);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] p;
      int l, r, g;
      for (int t = 0; t < 25; t++) begin
         p = 8'($urandom);
         l = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
         r = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
         g = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         build_model(p, l, r, g);
         applyStimulus(p, l, r, g);
         n_compared++;
         if (obs_done_at !== exp_v.size() + 1) begin
            n_failed++;
            $display("[TB] FAIL random%0d done_cycle: got %0d want %0d (len=%0d reps=%0d gap=%0d)",
                     t, obs_done_at, exp_v.size() + 1, l, r, g);
         end
         for (int i = 0; i < exp_v.size(); i++) begin
            n_compared++;
            if (i >= obs_v.size() || obs_v[i] !== exp_v[i] || obs_b[i] !== exp_b[i]) begin
               n_failed++;
               $display("[TB] FAIL random%0d bit%0d: got v=%b d=%b want v=%b d=%b", t, i,
                        (i < obs_v.size()) ? obs_v[i] : 1'bx, (i < obs_b.size()) ? obs_b[i] : 1'bx, exp_v[i], exp_b[i]);
            end
         end
         n_compared++;
         if (obs_hs_err !== 0 || obs_done_valid !== 1'b0 || obs_ready_after !== 1'b1 || obs_busy_after !== 1'b0 || obs_done_after !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL random%0d handshake: got errs=%0d dvalid=%b ready=%b busy=%b done=%b want 0 0 1 0 0",
                     t, obs_hs_err, obs_done_valid, obs_ready_after, obs_busy_after, obs_done_after);
         end
      end
   endtask

   task automatic test_reset_mid_send();
      int bad;
      bus.pat   = 8'hFF;
      bus.len   = 4'd8;
      bus.reps  = 4'd3;
      bus.gap   = 4'd1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_compared++;
      if (bus.ser_valid !== 1'b0 || bus.ser_out !== 1'b0) begin
         n_failed++;
         $display("[TB] FAIL midrst_stream: got valid=%b out=%b want 0 0", bus.ser_valid, bus.ser_out);
      end
      n_compared++;
      if (bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
         n_failed++;
         $display("[TB] FAIL midrst_status: got busy=%b ready=%b done=%b want 0 1 0", bus.busy, bus.ready, bus.done);
      end
      rst = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.ser_valid !== 1'b0 || bus.ready !== 1'b1) bad++;
      end
      n_compared++;
      if (bad !== 0) begin
         n_failed++;
         $display("[TB] FAIL midrst_quiet: got %0d active cycles want 0", bad);
      end
      build_model(8'h6D, 7, 2, 1);
      applyStimulus(8'h6D, 7, 2, 1);
      n_compared++;
      if (obs_done_at !== exp_v.size() + 1) begin
         n_failed++;
         $display("[TB] FAIL midrst_restart done_cycle: got %0d want %0d", obs_done_at, exp_v.size() + 1);
      end
      for (int i = 0; i < exp_v.size(); i++) begin
         n_compared++;
         if (i >= obs_v.size() || obs_v[i] !== exp_v[i] || obs_b[i] !== exp_b[i]) begin
            n_failed++;
            $display("[TB] FAIL midrst_restart bit%0d: got v=%b d=%b want v=%b d=%b", i,
                     (i < obs_v.size()) ? obs_v[i] : 1'bx, (i < obs_b.size()) ? obs_b[i] : 1'bx, exp_v[i], exp_b[i]);
         end
      end
   endtask

   // Guard against a hung run: report and stop if the sequence overruns.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed vectors, corner cases, then random traffic.
   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.pat   = 8'h00;
      bus.len   = 4'd0;
      bus.reps  = 4'd0;
      bus.gap   = 4'd0;
      test_reset();
      test_directed();
      test_degenerate();
      test_ignore_start();
      test_back_to_back();
      test_random();
      test_reset_mid_send();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter: the sending end of the serial sequence-detection link. It accepts a parallel pattern with a length, repeat count and inter-repeat gap, then shifts the pattern out MSB-first, one bit per clock, on a single serial line with a valid qualifier. It generates the stimulus streams that the Mealy sequence detector consumes, and also serves as a standalone test-pattern source in the FSM subsystem.

## Interface
- PAT_W, 8, maximum pattern length in bits
- LEN_W, 4, width of `len`; must hold PAT_W
- REP_W, 4, width of `reps`
- GAP_W, 4, width of `gap`
- clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  request strobe; sampled only while `ready`=1
- pat  in  PAT_W  pattern; bits `[len-1:0]` are sent
- len  in  LEN_W  bits per repetition; valid range 1..PAT_W
- reps  in  REP_W  number of repetitions; valid range 1..2^REP_W-1
- gap  in  GAP_W  idle cycles between repetitions
- ready  out  1  high in IDLE only
- busy  out  1  high from acceptance until the DONE cycle, inclusive
- done  out  1  one-cycle completion pulse
- ser_out  out  1  serial data
- ser_valid  out  1  ser_out carries a pattern bit

## Operation
- FSM states: IDLE, SEND, GAP, DONE. All outputs are registered.
- IDLE: `ready`=1, `busy`=0. When `start`=1, capture `pat`, `len`, `reps` and `gap`, then go to SEND.
- Degenerate requests:
  - `len`=0 or `reps`=0: go directly to DONE; no bits are sent.
  - `len`>PAT_W: clamp to PAT_W.
- SEND: drive bit index `len-1` down to 0 of the captured pattern, one bit per cycle, with `ser_valid`=1.
- After the last bit of a repetition:
  - More repetitions remain and `gap`>0: go to GAP.
  - More repetitions remain and `gap`=0: start the next repetition in the next cycle, with no bubble.
  - Final repetition: go to DONE.
- GAP: hold `ser_out`=0 and `ser_valid`=0 for exactly `gap` cycles, then return to SEND for the next repetition.
- DONE: `done`=1 and `busy`=1 for one cycle, with `ser_valid`=0; then go to IDLE.
- `start` is ignored in every state except IDLE. Input changes after capture have no effect.
- Whenever `ser_valid`=0, `ser_out`=0.
- Reset values: `ready`=1, `busy`=0, `done`=0, `ser_out`=0, `ser_valid`=0. State goes to IDLE and all counters clear.
- Reset mid-operation aborts the transfer immediately, with no `done` pulse.

## Timing
- `start` accepted in cycle T: the first bit is valid in cycle T+1, and `ready` falls in cycle T+1.
- Last bit is in cycle T + reps·len + (reps−1)·gap.
- `done` is high in the following cycle.
- `ready` is high one cycle after `done`, and a new `start` is accepted in that cycle.
- Degenerate request: `done` in T+1, `ready` in T+2.
- Bit counter is LEN_W wide and counts down from `len-1` to 0.
- Repetition counter is REP_W wide and counts down.
- Gap counter is GAP_W wide.
- No counter wraps. The terminal value 0 triggers each transition.
- `rst` asserted in cycle R: reset values are visible from cycle R+1 and dominate `start` in the same cycle.

## Structure
- Package `seq_pattern_pkg`:
  - state enum (IDLE, SEND, GAP, DONE)
  - default width constants PAT_W, LEN_W, REP_W, GAP_W
- Sub-module `seq_pattern_piso`:
  - PAT_W-bit parallel-load, MSB-first shift register with a load/shift enable
  - exports the current bit, aligned to index `len-1` at load
- Top level holds the FSM and the repetition and gap counters.

## Test plan
- `pat`=8'b0000_0101, `len`=3, `reps`=1, `gap`=0, `start` at T → `ser_out` 1,0,1 with `ser_valid`=1 at T+1..T+3; `done` at T+4; `ready` at T+5.
- Same pattern, `reps`=2, `gap`=0, connected to the Mealy detector → stream 101101; the detector `out` is high on the cycles carrying bit 3 and bit 6.
- `len`=2, `pat`=2'b10, `reps`=3, `gap`=2 → 1,0,(idle),(idle),1,0,(idle),(idle),1,0 with `ser_valid` low in the gaps; `done` at T+11.
- `len`=0 with `reps`=5, and separately `reps`=0 → no valid bits; `done` at T+1; `ready` at T+2. `len`=12 → exactly 8 bits sent.
- `start` pulsed during SEND with a different `pat` → ignored; the original stream completes unchanged.
- `rst` high mid-SEND → next cycle `ser_valid`=0, `busy`=0, `ready`=1, no `done` pulse; a new `start` is then accepted normally.
